// File: rtl/risc8_pkg.sv
// Shared definitions for the risc8 control path: opcodes, control-word bit
// positions and the sequencer state encoding.
package risc8_pkg;

    localparam int unsigned CTRLW          = 16;
    localparam int unsigned LAST_EXEC_STEP = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int unsigned C_PC_OUT  = 0;
    localparam int unsigned C_PC_INC  = 1;
    localparam int unsigned C_PC_LOAD = 2;
    localparam int unsigned C_MAR_IN  = 3;
    localparam int unsigned C_RAM_OUT = 4;
    localparam int unsigned C_RAM_IN  = 5;
    localparam int unsigned C_IR_IN   = 6;
    localparam int unsigned C_A_IN    = 7;
    localparam int unsigned C_A_OUT   = 8;
    localparam int unsigned C_B_IN    = 9;
    localparam int unsigned C_ALU_OUT = 10;
    localparam int unsigned C_ALU_SUB = 11;
    localparam int unsigned C_OUT_IN  = 12;
    localparam int unsigned C_HALT    = 13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } seq_state_e;

    // A step touching RAM must wait for the memory handshake.
    function automatic logic is_mem_step(input logic [CTRLW-1:0] word);
        return word[C_RAM_OUT] | word[C_RAM_IN];
    endfunction

endpackage

// File: rtl/micro_sequencer_rom.sv
// Combinational microcode: {opcode, step, zero_flag} -> control word and
// an end-of-instruction marker.
module microcode_rom
    import risc8_pkg::*;
#(
    parameter int unsigned OPW   = 4,
    parameter int unsigned STEPW = 3
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [STEPW-1:0] step,
    input  logic             zero_flag,
    output logic [CTRLW-1:0] ctrl,
    output logic             last
);

    localparam logic [STEPW-1:0] T0 = STEPW'(0);
    localparam logic [STEPW-1:0] T1 = STEPW'(1);
    localparam logic [STEPW-1:0] T2 = STEPW'(2);
    localparam logic [STEPW-1:0] T3 = STEPW'(3);
    localparam logic [STEPW-1:0] T4 = STEPW'(4);

    logic is_sub;
    assign is_sub = (opcode == OPW'(OP_SUB));

    always_comb begin
        ctrl = '0;
        last = 1'b0;
        if (step == T0) begin
            ctrl[C_PC_OUT] = 1'b1;
            ctrl[C_MAR_IN] = 1'b1;
        end else if (step == T1) begin
            ctrl[C_RAM_OUT] = 1'b1;
            ctrl[C_IR_IN]   = 1'b1;
            ctrl[C_PC_INC]  = 1'b1;
        end else begin
            // Execute phase; steps with no entry decode to an idle word.
            case (opcode)
                OPW'(OP_LDA): begin
                    if (step == T2) begin
                        ctrl[C_MAR_IN] = 1'b1;
                    end else if (step == T3) begin
                        ctrl[C_RAM_OUT] = 1'b1;
                        ctrl[C_A_IN]    = 1'b1;
                        last            = 1'b1;
                    end
                end
                OPW'(OP_ADD), OPW'(OP_SUB): begin
                    if (step == T2) begin
                        ctrl[C_MAR_IN] = 1'b1;
                    end else if (step == T3) begin
                        ctrl[C_RAM_OUT] = 1'b1;
                        ctrl[C_B_IN]    = 1'b1;
                        ctrl[C_ALU_SUB] = is_sub;
                    end else if (step == T4) begin
                        ctrl[C_ALU_OUT] = 1'b1;
                        ctrl[C_A_IN]    = 1'b1;
                        ctrl[C_ALU_SUB] = is_sub;
                        last            = 1'b1;
                    end
                end
                OPW'(OP_STA): begin
                    if (step == T2) begin
                        ctrl[C_MAR_IN] = 1'b1;
                    end else if (step == T3) begin
                        ctrl[C_A_OUT]  = 1'b1;
                        ctrl[C_RAM_IN] = 1'b1;
                        last           = 1'b1;
                    end
                end
                OPW'(OP_LDI): begin
                    if (step == T2) begin
                        ctrl[C_A_IN] = 1'b1;
                        last         = 1'b1;
                    end
                end
                OPW'(OP_JMP): begin
                    if (step == T2) begin
                        ctrl[C_PC_LOAD] = 1'b1;
                        last            = 1'b1;
                    end
                end
                OPW'(OP_JZ): begin
                    if (step == T2) begin
                        ctrl[C_PC_LOAD] = zero_flag;
                        last            = 1'b1;
                    end
                end
                OPW'(OP_OUT): begin
                    if (step == T2) begin
                        ctrl[C_A_OUT]  = 1'b1;
                        ctrl[C_OUT_IN] = 1'b1;
                        last           = 1'b1;
                    end
                end
                OPW'(OP_HLT): begin
                    if (step == T2) begin
                        ctrl[C_HALT] = 1'b1;
                        last         = 1'b1;
                    end
                end
                default: begin
                    if (step == T2) begin
                        last = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// risc8 control unit: microstep counter, run/wait/halt state machine and
// the control word driven to the datapath enables.
module micro_sequencer
    import risc8_pkg::*;
#(
    parameter int unsigned OPW   = 4,
    parameter int unsigned STEPW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [OPW-1:0]   opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic [STEPW-1:0] step,
    output logic [CTRLW-1:0] ctrl,
    output logic             instr_done,
    output logic             halted
);

    localparam logic [STEPW-1:0] FIRST_DEAD = STEPW'(LAST_EXEC_STEP + 1);

    seq_state_e       state, state_nxt;
    logic [STEPW-1:0] step_nxt;
    logic [CTRLW-1:0] hold_ctrl, hold_ctrl_nxt;
    logic             hold_last, hold_last_nxt;

    logic [CTRLW-1:0] rom_ctrl;
    logic             rom_last;
    logic [CTRLW-1:0] word;
    logic             fin;
    logic             advance;

    microcode_rom #(
        .OPW   (OPW),
        .STEPW (STEPW)
    ) u_rom (
        .opcode    (opcode),
        .step      (step),
        .zero_flag (zero_flag),
        .ctrl      (rom_ctrl),
        .last      (rom_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            step      <= '0;
            hold_ctrl <= '0;
            hold_last <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            hold_ctrl <= hold_ctrl_nxt;
            hold_last <= hold_last_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        step_nxt      = step;
        hold_ctrl_nxt = hold_ctrl;
        hold_last_nxt = hold_last;
        ctrl          = '0;
        instr_done    = 1'b0;
        halted        = 1'b0;
        word          = '0;
        fin           = 1'b0;
        advance       = 1'b0;

        case (state)
            S_IDLE: begin
                step_nxt = '0;
                if (run) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                ctrl = rom_ctrl;
                word = rom_ctrl;
                fin  = rom_last;
                if (is_mem_step(rom_ctrl) && !mem_ready) begin
                    // Freeze the word so the datapath sees it unchanged while waiting.
                    state_nxt     = S_WAIT;
                    hold_ctrl_nxt = rom_ctrl;
                    hold_last_nxt = rom_last;
                end else begin
                    advance = 1'b1;
                end
            end
            S_WAIT: begin
                ctrl = hold_ctrl;
                word = hold_ctrl;
                fin  = hold_last;
                if (mem_ready) begin
                    state_nxt = S_RUN;
                    advance   = 1'b1;
                end
            end
            S_HALT: begin
                ctrl[C_HALT] = 1'b1;
                halted       = 1'b1;
                step_nxt     = '0;
            end
        endcase

        // End clears the step; unreachable steps fall back to T0 without a done pulse.
        if (advance) begin
            if (fin) begin
                instr_done = 1'b1;
                step_nxt   = '0;
                if (word[C_HALT]) begin
                    state_nxt = S_HALT;
                end else if (run) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end else if (step >= FIRST_DEAD) begin
                step_nxt = '0;
            end else begin
                step_nxt = step + STEPW'(1);
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [3:0]  opcode;
    logic        zero_flag;
    logic        mem_ready;
    logic [2:0]  step;
    logic [15:0] ctrl;
    logic        instr_done;
    logic        halted;

    int n_cmp  = 0;
    int n_fail = 0;

    micro_sequencer #(.OPW(4), .STEPW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .zero_flag  (zero_flag),
        .mem_ready  (mem_ready),
        .step       (step),
        .ctrl       (ctrl),
        .instr_done (instr_done),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b0; mem_ready = 1'b1; zero_flag = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int es[4] = '{0, 1, 2, 3};
        int ec[4] = '{16'h0009, 16'h0052, 16'h0008, 16'h0210};
        do_reset();
        #1;
        n_cmp++; if (step !== 3'd0)  begin n_fail++; $display("FAIL reset_step got %0d want 0", step); end
        n_cmp++; if (ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0000", ctrl); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_cmp++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", instr_done); end
        opcode = 4'h2; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (step !== 3'(es[i])) begin n_fail++; $display("FAIL rst_add_step c%0d got %0d want %0d", i, step, es[i]); end
            n_cmp++; if (ctrl !== 16'(ec[i])) begin n_fail++; $display("FAIL rst_add_ctrl c%0d got %h want %h", i, ctrl, 16'(ec[i])); end
        end
        reset = 1'b1; #1;
        n_cmp++; if (step !== 3'd0)  begin n_fail++; $display("FAIL midreset_step got %0d want 0", step); end
        n_cmp++; if (ctrl !== 16'h0) begin n_fail++; $display("FAIL midreset_ctrl got %h want 0000", ctrl); end
        n_cmp++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b want 0", instr_done); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (step !== 3'd0) begin n_fail++; $display("FAIL resume_step got %0d want 0", step); end
        n_cmp++; if (ctrl !== 16'h0009) begin n_fail++; $display("FAIL resume_ctrl got %h want 0009", ctrl); end
    endtask

    task automatic test_ldi_out();
        int op[6] = '{4'h5, 4'h5, 4'h5, 4'hE, 4'hE, 4'hE};
        int es[6] = '{0, 1, 2, 0, 1, 2};
        int ec[6] = '{16'h0009, 16'h0052, 16'h0080, 16'h0009, 16'h0052, 16'h1100};
        int ed[6] = '{0, 0, 1, 0, 0, 1};
        do_reset();
        opcode = 4'h5; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            opcode = 4'(op[i]);
            #1;
            n_cmp++; if (step !== 3'(es[i])) begin n_fail++; $display("FAIL ldi_out_step c%0d got %0d want %0d", i, step, es[i]); end
            n_cmp++; if (ctrl !== 16'(ec[i])) begin n_fail++; $display("FAIL ldi_out_ctrl c%0d got %h want %h", i, ctrl, 16'(ec[i])); end
            n_cmp++; if (instr_done !== 1'(ed[i])) begin n_fail++; $display("FAIL ldi_out_done c%0d got %b want %0d", i, instr_done, ed[i]); end
        end
    endtask

    task automatic test_wait();
        int mr[9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
        int es[9] = '{0, 1, 1, 1, 1, 2, 3, 4, 0};
        int ec[9] = '{16'h0009, 16'h0052, 16'h0052, 16'h0052, 16'h0052,
                      16'h0008, 16'h0210, 16'h0480, 16'h0009};
        int ed[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        do_reset();
        opcode = 4'h2; run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            mem_ready = 1'(mr[i]);
            #1;
            n_cmp++; if (step !== 3'(es[i])) begin n_fail++; $display("FAIL wait_step c%0d got %0d want %0d", i, step, es[i]); end
            n_cmp++; if (ctrl !== 16'(ec[i])) begin n_fail++; $display("FAIL wait_ctrl c%0d got %h want %h", i, ctrl, 16'(ec[i])); end
            n_cmp++; if (instr_done !== 1'(ed[i])) begin n_fail++; $display("FAIL wait_done c%0d got %b want %0d", i, instr_done, ed[i]); end
        end
    endtask

    task automatic test_jz();
        int zf[7] = '{0, 0, 0, 1, 1, 1, 1};
        int es[7] = '{0, 1, 2, 0, 1, 2, 0};
        int ec[7] = '{16'h0009, 16'h0052, 16'h0000, 16'h0009, 16'h0052, 16'h0004, 16'h0009};
        int ed[7] = '{0, 0, 1, 0, 0, 1, 0};
        do_reset();
        opcode = 4'h7; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            zero_flag = 1'(zf[i]);
            #1;
            n_cmp++; if (step !== 3'(es[i])) begin n_fail++; $display("FAIL jz_step c%0d got %0d want %0d", i, step, es[i]); end
            n_cmp++; if (ctrl !== 16'(ec[i])) begin n_fail++; $display("FAIL jz_ctrl c%0d got %h want %h", i, ctrl, 16'(ec[i])); end
            n_cmp++; if (instr_done !== 1'(ed[i])) begin n_fail++; $display("FAIL jz_done c%0d got %b want %0d", i, instr_done, ed[i]); end
        end
    endtask

    task automatic test_halt();
        int es[3] = '{0, 1, 2};
        int ec[3] = '{16'h0009, 16'h0052, 16'h2000};
        int ed[3] = '{0, 0, 1};
        do_reset();
        opcode = 4'hF; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (step !== 3'(es[i])) begin n_fail++; $display("FAIL hlt_step c%0d got %0d want %0d", i, step, es[i]); end
            n_cmp++; if (ctrl !== 16'(ec[i])) begin n_fail++; $display("FAIL hlt_ctrl c%0d got %h want %h", i, ctrl, 16'(ec[i])); end
            n_cmp++; if (instr_done !== 1'(ed[i])) begin n_fail++; $display("FAIL hlt_done c%0d got %b want %0d", i, instr_done, ed[i]); end
            n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hlt_early c%0d got %b want 0", i, halted); end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run = 1'(i % 2);
            #1;
            n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halted c%0d got %b want 1", i, halted); end
            n_cmp++; if (step !== 3'd0) begin n_fail++; $display("FAIL halted_step c%0d got %0d want 0", i, step); end
            n_cmp++; if (ctrl !== 16'h2000) begin n_fail++; $display("FAIL halted_ctrl c%0d got %h want 2000", i, ctrl); end
            n_cmp++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL halted_done c%0d got %b want 0", i, instr_done); end
        end
        reset = 1'b1; #1;
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear got %b want 0", halted); end
        n_cmp++; if (ctrl !== 16'h0) begin n_fail++; $display("FAIL halt_clear_ctrl got %h want 0000", ctrl); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_run_drop();
        int rn[7] = '{1, 1, 0, 0, 0, 1, 1};
        int es[7] = '{0, 1, 2, 3, 0, 0, 0};
        int ec[7] = '{16'h0009, 16'h0052, 16'h0008, 16'h0090, 16'h0000, 16'h0000, 16'h0009};
        int ed[7] = '{0, 0, 0, 1, 0, 0, 0};
        do_reset();
        opcode = 4'h1; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            run = 1'(rn[i]);
            #1;
            n_cmp++; if (step !== 3'(es[i])) begin n_fail++; $display("FAIL rundrop_step c%0d got %0d want %0d", i, step, es[i]); end
            n_cmp++; if (ctrl !== 16'(ec[i])) begin n_fail++; $display("FAIL rundrop_ctrl c%0d got %h want %h", i, ctrl, 16'(ec[i])); end
            n_cmp++; if (instr_done !== 1'(ed[i])) begin n_fail++; $display("FAIL rundrop_done c%0d got %b want %0d", i, instr_done, ed[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int op[16] = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h4, 4'h4, 4'h4, 4'h4,
                       4'h6, 4'h6, 4'h6, 4'h9, 4'h9, 4'h9, 4'h9};
        int es[16] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 0, 1, 2, 0, 1, 2, 0};
        int ec[16] = '{16'h0009, 16'h0052, 16'h0008, 16'h0A10, 16'h0C80,
                       16'h0009, 16'h0052, 16'h0008, 16'h0120,
                       16'h0009, 16'h0052, 16'h0004,
                       16'h0009, 16'h0052, 16'h0000, 16'h0009};
        int ed[16] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        do_reset();
        opcode = 4'h3; run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            opcode = 4'(op[i]);
            #1;
            n_cmp++; if (step !== 3'(es[i])) begin n_fail++; $display("FAIL b2b_step c%0d got %0d want %0d", i, step, es[i]); end
            n_cmp++; if (ctrl !== 16'(ec[i])) begin n_fail++; $display("FAIL b2b_ctrl c%0d got %h want %h", i, ctrl, 16'(ec[i])); end
            n_cmp++; if (instr_done !== 1'(ed[i])) begin n_fail++; $display("FAIL b2b_done c%0d got %b want %0d", i, instr_done, ed[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; opcode = 4'h0; zero_flag = 1'b0; mem_ready = 1'b1;
        test_reset();
        test_ldi_out();
        test_wait();
        test_jz();
        test_halt();
        test_run_drop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
